// File: rtl/pe_mac_pool_if.sv
// Load/control/result bundle of one conv/pool PE: scratchpad write ports,
// start command, and the valid/ready result channel.
interface pe_mac_pool_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int OUT_WIDTH  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                  act_wr_en;
    logic [AW-1:0]         act_wr_addr;
    logic [DATA_WIDTH-1:0] act_wr_data;
    logic                  wt_wr_en;
    logic [AW-1:0]         wt_wr_addr;
    logic [DATA_WIDTH-1:0] wt_wr_data;
    logic                  start;
    logic                  mode;
    logic                  relu_en;
    logic [AW:0]           len;
    logic [DATA_WIDTH-1:0] bias_in;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  pe_out;
    logic                  overflow;
    logic [1:0]            dbg_state;

    // Result transfers on a rising edge where out_valid && out_ready; once raised,
    // out_valid, pe_out and overflow stay put until that transfer.
    modport master (
        output act_wr_en, act_wr_addr, act_wr_data,
        output wt_wr_en, wt_wr_addr, wt_wr_data,
        output start, mode, relu_en, len, bias_in, out_ready,
        input  busy, out_valid, pe_out, overflow, dbg_state
    );

    modport slave (
        input  act_wr_en, act_wr_addr, act_wr_data,
        input  wt_wr_en, wt_wr_addr, wt_wr_data,
        input  start, mode, relu_en, len, bias_in, out_ready,
        output busy, out_valid, pe_out, overflow, dbg_state
    );
endinterface

// File: rtl/pe_mac_pool.sv
// Conv/pool processing element: scratchpad-fed signed MAC or running max over
// a programmable length, then optional ReLU and saturation to OUT_WIDTH.
module pe_mac_pool #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int OUT_WIDTH  = 16
) (
    input logic          clk,
    input logic          rst,
    pe_mac_pool_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int DW  = DATA_WIDTH;
    localparam int ACW = ACC_WIDTH;
    localparam int OW  = OUT_WIDTH;

    localparam logic signed [ACW-1:0] SAT_MAX   = {{(ACW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACW-1:0] SAT_MIN   = {{(ACW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam logic signed [ACW-1:0] POOL_INIT = {{(ACW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [AW:0]           LEN_MAX   = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINAL = 2'd2, OUT = 2'd3} state_t;

    state_t                 state_q;
    logic [AW:0]            idx_q, len_q;
    logic                   mode_q, relu_q;
    logic signed [ACW-1:0]  acc_q;
    logic [OW-1:0]          pe_out_q;
    logic                   ovf_q, out_valid_q;

    logic signed [DW-1:0]   act_mem [DEPTH];
    logic signed [DW-1:0]   wt_mem  [DEPTH];

    // Scratchpads have no reset; a same-cycle write is seen by RUN one cycle later.
    always_ff @(posedge clk) begin
        if (bus.act_wr_en) act_mem[bus.act_wr_addr] <= bus.act_wr_data;
        if (bus.wt_wr_en)  wt_mem[bus.wt_wr_addr]   <= bus.wt_wr_data;
    end

    logic signed [DW-1:0]   act_rd, wt_rd;
    logic signed [2*DW-1:0] prod;
    logic signed [ACW-1:0]  act_ext, prod_ext, bias_ext, acc_d, relu_r;
    logic [AW:0]            len_d;
    logic [OW-1:0]          pe_out_d;
    logic                   ovf_d;

    assign act_rd   = act_mem[idx_q[AW-1:0]];
    assign wt_rd    = wt_mem[idx_q[AW-1:0]];
    assign prod     = act_rd * wt_rd;
    assign act_ext  = {{(ACW-DW){act_rd[DW-1]}}, act_rd};
    assign prod_ext = {{(ACW-2*DW){prod[2*DW-1]}}, prod};
    assign bias_ext = {{(ACW-DW){bus.bias_in[DW-1]}}, bus.bias_in};
    assign acc_d    = mode_q ? ((act_ext > acc_q) ? act_ext : acc_q) : (acc_q + prod_ext);
    assign len_d    = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;

    assign relu_r   = (relu_q && acc_q[ACW-1]) ? '0 : acc_q;
    assign ovf_d    = (relu_r > SAT_MAX) || (relu_r < SAT_MIN);
    assign pe_out_d = (relu_r > SAT_MAX) ? SAT_MAX[OW-1:0] :
                      (relu_r < SAT_MIN) ? SAT_MIN[OW-1:0] : relu_r[OW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            mode_q      <= 1'b0;
            relu_q      <= 1'b0;
            acc_q       <= '0;
            pe_out_q    <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        idx_q   <= '0;
                        len_q   <= len_d;
                        mode_q  <= bus.mode;
                        relu_q  <= bus.relu_en;
                        acc_q   <= bus.mode ? POOL_INIT : bias_ext;
                        state_q <= (len_d == '0) ? FINAL : RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == len_q - 1'b1) state_q <= FINAL;
                end
                FINAL: begin
                    pe_out_q    <= pe_out_d;
                    ovf_q       <= ovf_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.pe_out    = pe_out_q;
    assign bus.overflow  = ovf_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_pe_mac_pool.sv
// Bench for pe_mac_pool: directed vector table, backpressure/reset/collision
// sequences, and randomized operations against an arithmetic reference model.
module tb_pe_mac_pool;
    logic clk;
    logic rst;

    pe_mac_pool_if #(.DATA_WIDTH(8), .DEPTH(16), .OUT_WIDTH(16)) bus ();

    pe_mac_pool #(.DATA_WIDTH(8), .DEPTH(16), .ACC_WIDTH(24), .OUT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             mode;
        logic             relu;
        logic [4:0]       len;
        logic [7:0]       bias;
        logic [15:0][7:0] act;
        logic [15:0][7:0] wt;
        logic [15:0]      exp_out;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs [10];
    int   act_m [16];
    int   wt_m  [16];
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        else n_pass++;
    endtask

    // Reference: plain integer arithmetic over the bench's own scratchpad copy.
    function automatic logic [16:0] model(input logic m, input logic r, input logic [4:0] l,
                                          input logic signed [7:0] b);
        int          n;
        longint      acc;
        logic [63:0] t;
        n   = (l > 5'd16) ? 16 : int'(l);
        acc = m ? -128 : longint'(b);
        for (int i = 0; i < n; i++) begin
            if (m) begin
                if (act_m[i] > acc) acc = act_m[i];
            end else begin
                acc += act_m[i] * wt_m[i];
            end
        end
        if (r && acc < 0) acc = 0;
        if (acc > 32767) return {1'b1, 16'h7FFF};
        if (acc < -32768) return {1'b1, 16'h8000};
        t = acc;
        return {1'b0, t[15:0]};
    endfunction

    task automatic load_pair(input int a, input logic [7:0] av, input logic [7:0] wv);
        bus.act_wr_en   = 1'b1;
        bus.act_wr_addr = 4'(a);
        bus.act_wr_data = av;
        bus.wt_wr_en    = 1'b1;
        bus.wt_wr_addr  = 4'(a);
        bus.wt_wr_data  = wv;
        @(negedge clk);
        bus.act_wr_en = 1'b0;
        bus.wt_wr_en  = 1'b0;
        act_m[a] = int'($signed(av));
        wt_m[a]  = int'($signed(wv));
    endtask

    // Called at a negedge; returns at the negedge after the result handshake.
    task automatic run_op(input logic m, input logic r, input logic [4:0] l, input logic [7:0] b,
                          input int hold, input logic [15:0] exp_pe, input logic exp_ovf,
                          input string tag);
        int cyc;
        int exp_lat;
        bit seen;
        exp_lat       = ((l > 5'd16) ? 16 : int'(l)) + 2;
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.relu_en   = r;
        bus.len       = l;
        bus.bias_in   = b;
        bus.out_ready = (hold == 0);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
            if (bus.out_valid) seen = 1;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        if (!seen) return;
        check({tag, "_pe_out"}, 32'(bus.pe_out), 32'(exp_pe));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                bus.start = 1'b1;
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
                check({tag, "_hold_busy"}, 32'(bus.busy), 32'd1);
                check({tag, "_hold_pe"}, 32'(bus.pe_out), 32'(exp_pe));
                check({tag, "_hold_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
            end
            bus.out_ready = 1'b1;
        end
        bus.start = (hold > 0);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_post_pe"}, 32'(bus.pe_out), 32'(exp_pe));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] e;
        logic        rm, rr;
        logic [4:0]  rl;
        logic [7:0]  rb, av, wv;
        int          cyc;

        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        bus.act_wr_en = 1'b0; bus.act_wr_addr = '0; bus.act_wr_data = '0;
        bus.wt_wr_en  = 1'b0; bus.wt_wr_addr  = '0; bus.wt_wr_data  = '0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.relu_en = 1'b0; bus.len = '0;
        bus.bias_in = '0; bus.out_ready = 1'b1;

        for (int v = 0; v < 10; v++) vecs[v] = '0;
        vecs[0].len = 5'd4; vecs[0].bias = 8'd10; vecs[0].exp_out = 16'd80;
        for (int i = 0; i < 4; i++) begin
            vecs[0].act[i] = 8'(i + 1);
            vecs[0].wt[i]  = 8'(i + 5);
        end
        vecs[1].len = 5'd16; vecs[1].exp_out = 16'h7FFF; vecs[1].exp_ovf = 1'b1;
        vecs[2].len = 5'd16; vecs[2].exp_out = 16'h8000; vecs[2].exp_ovf = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vecs[1].act[i] = 8'h80; vecs[1].wt[i] = 8'h80;
            vecs[2].act[i] = 8'h80; vecs[2].wt[i] = 8'h7F;
        end
        vecs[3].len = 5'd2; vecs[3].exp_out = 16'hFFE2;
        vecs[4].len = 5'd2; vecs[4].relu = 1'b1; vecs[4].exp_out = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            vecs[3].act[i] = 8'd3; vecs[3].wt[i] = 8'hFB;
            vecs[4].act[i] = 8'd3; vecs[4].wt[i] = 8'hFB;
        end
        vecs[5].mode = 1'b1; vecs[5].len = 5'd5; vecs[5].exp_out = 16'd12;
        vecs[5].act[0] = 8'hF9; vecs[5].act[1] = 8'd12; vecs[5].act[2] = 8'h9C;
        vecs[5].act[3] = 8'd12; vecs[5].act[4] = 8'd3;
        vecs[6].mode = 1'b1; vecs[6].len = 5'd0; vecs[6].exp_out = 16'hFF80;
        vecs[7].len = 5'd0; vecs[7].bias = 8'hFD; vecs[7].exp_out = 16'hFFFD;
        vecs[8].len = 5'd20; vecs[8].exp_out = 16'd32;
        vecs[9].mode = 1'b1; vecs[9].relu = 1'b1; vecs[9].len = 5'd0; vecs[9].exp_out = 16'd0;
        for (int i = 0; i < 16; i++) begin
            vecs[7].act[i] = 8'd1; vecs[7].wt[i] = 8'd1;
            vecs[8].act[i] = 8'd1; vecs[8].wt[i] = 8'd2;
        end

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        check("reset_pe_out", 32'(bus.pe_out), 32'd0);
        check("reset_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 16; i++) load_pair(i, vecs[v].act[i], vecs[v].wt[i]);
            run_op(vecs[v].mode, vecs[v].relu, vecs[v].len, vecs[v].bias, 0,
                   vecs[v].exp_out, vecs[v].exp_ovf, $sformatf("vec%0d", v));
        end

        // Same-cycle write to the address being read: old data goes into the sum.
        for (int i = 0; i < 16; i++) load_pair(i, (i < 8) ? 8'(i + 1) : 8'd0, (i < 8) ? 8'd1 : 8'd0);
        bus.start = 1'b1; bus.mode = 1'b0; bus.relu_en = 1'b0; bus.len = 5'd8;
        bus.bias_in = 8'd0; bus.out_ready = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.act_wr_en = 1'b1; bus.act_wr_addr = 4'd2; bus.act_wr_data = 8'd100;
        @(negedge clk);
        bus.act_wr_en = 1'b0;
        act_m[2] = 100;
        cyc = 4;
        while (!bus.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("collide_latency", 32'(cyc), 32'd10);
        check("collide_pe_out", 32'(bus.pe_out), 32'd36);
        @(negedge clk);

        // Reset in the middle of RUN aborts the operation.
        bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_pe_out", 32'(bus.pe_out), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_no_result", 32'(bus.out_valid), 32'd0);
        e = model(1'b0, 1'b0, 5'd8, 8'd0);
        run_op(1'b0, 1'b0, 5'd8, 8'd0, 0, e[15:0], e[16], "after_rst");

        // Backpressure, then a start in the first idle cycle.
        e = model(1'b0, 1'b0, 5'd8, 8'hF0);
        run_op(1'b0, 1'b0, 5'd8, 8'hF0, 10, e[15:0], e[16], "bp");
        e = model(1'b1, 1'b0, 5'd3, 8'd0);
        run_op(1'b1, 1'b0, 5'd3, 8'd0, 0, e[15:0], e[16], "bp_next");

        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < 16; i++) begin
                av = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'h80 : 8'h7F)
                                                 : 8'($urandom_range(0, 255));
                wv = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'h80 : 8'h7F)
                                                 : 8'($urandom_range(0, 255));
                load_pair(i, av, wv);
            end
            rm = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            rl = 5'($urandom_range(0, 20));
            rb = 8'($urandom_range(0, 255));
            e  = model(rm, rr, rl, rb);
            run_op(rm, rr, rl, rb, $urandom_range(0, 3), e[15:0], e[16], $sformatf("rand%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pe_mac_pool.md
Name: pe_mac_pool

Overview:
Second-generation processing element for the conv/pool array. It holds parametrised-depth activation and weight scratchpads and runs a multi-element signed MAC (conv mode) or running max (pool mode) over a programmable length. Optional ReLU and output saturation are applied, and the result is returned on a valid/ready output handshake. It replaces the single-entry, single-product PE and sits in each array cell between the global buffer feed and the output-feature collector.

Parameters:
DATA_WIDTH, 8, signed activation/weight/bias width
DEPTH, 16, entries per scratchpad; AW = clog2(DEPTH)
ACC_WIDTH, 24, signed accumulator width; must be >= 2*DATA_WIDTH+clog2(DEPTH)+1 (no internal wrap)
OUT_WIDTH, 16, signed result width; must be <= ACC_WIDTH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
act_wr_en  in  1  write activation scratchpad
act_wr_addr  in  AW  activation write index
act_wr_data  in  DATA_WIDTH  activation value (signed)
wt_wr_en  in  1  write weight scratchpad
wt_wr_addr  in  AW  weight write index
wt_wr_data  in  DATA_WIDTH  weight value (signed)
start  in  1  begin operation; accepted only when busy=0
mode  in  1  0=conv MAC, 1=max-pool; sampled on accepted start
relu_en  in  1  clamp negatives to 0; sampled on accepted start
len  in  AW+1  element count 0..DEPTH; sampled on accepted start
bias_in  in  DATA_WIDTH  signed conv bias; sampled on accepted start
busy  out  1  high whenever state != IDLE
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
pe_out  out  OUT_WIDTH  signed result
overflow  out  1  saturation occurred; qualified by out_valid

Behaviour:
- Reset: state IDLE; busy=0, out_valid=0, pe_out=0, overflow=0; index and accumulator cleared. Scratchpad contents are not reset (undefined after power-up). Reset mid-operation aborts; no result is produced.
- Scratchpads: one write port each, usable in any state. Reads are combinational at the current index. A write and a RUN read to the same address in the same cycle return the old data; the new data is visible next cycle.
- FSM: IDLE -> RUN on start (len>0); IDLE -> FINAL on start (len==0); RUN -> FINAL after element len-1; FINAL -> OUT; OUT -> IDLE on out_valid && out_ready.
- Start: start while busy=1 (including the handshake cycle) is ignored. len > DEPTH is clamped to DEPTH.
- Init on accepted start: index=0. conv: acc = sign-extended bias_in. pool: acc = -2^(DATA_WIDTH-1) sign-extended.
- RUN: one element per cycle at index i.
  - conv: acc += sext(act[i]) * sext(wt[i]), full 2*DATA_WIDTH signed product.
  - pool: acc = max(acc, sext(act[i])); the weight scratchpad is ignored.
- FINAL: r = relu_en && acc<0 ? 0 : acc.
  - If r > 2^(OUT_WIDTH-1)-1: pe_out = max, overflow=1.
  - If r < -2^(OUT_WIDTH-1): pe_out = min, overflow=1.
  - Otherwise pe_out = r[OUT_WIDTH-1:0], overflow=0.
  - pe_out and overflow are registered; out_valid=1 entering OUT.
- Latency: with start high in cycle 0, out_valid is first high in cycle len+2 (cycle 2 for len=0).
- OUT: pe_out, overflow and out_valid are held stable until the handshake. After the handshake, out_valid=0 and busy=0 next cycle; pe_out keeps its last value.
- Signed two's-complement throughout; no rounding.

Test Plan:
1. Conv, len=4, act={1,2,3,4}, wt={5,6,7,8}, bias=10, relu off, out_ready=1 -> pe_out=80, overflow=0, out_valid high in cycle 6 for exactly 1 cycle.
2. Conv saturation: all 16 act=-128 and wt=-128, len=16, bias=0 -> acc=262144, pe_out=32767 (0x7FFF), overflow=1. Repeat with wt=127 -> acc=-260096, pe_out=-32768 (0x8000), overflow=1.
3. ReLU: act={3,3}, wt={-5,-5}, len=2, bias=0 -> relu off: pe_out=0xFFE2 (-30); relu on: pe_out=0, overflow=0.
4. Pool: act={-7,12,-100,12,3}, len=5 -> pe_out=12. len=0, relu off -> pe_out=0xFF80 (-128), out_valid in cycle 2. Conv len=0, bias=-3 -> 0xFFFD. len=20 behaves as len=16.
5. Backpressure: out_ready low for 10 cycles after out_valid -> pe_out/overflow/out_valid stable and busy=1. Start pulses in those cycles and in the handshake cycle are ignored. A start one cycle after busy falls is accepted.
6. Reset mid-RUN (cycle 3 of len=8) -> next cycle busy=0, out_valid=0, pe_out=0. A write to act[2] in the same cycle RUN reads index 2 -> old value used in the sum.
